// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the light-sensor acquisition controller.
package spi_ctrl_pkg;

   localparam int unsigned WORD_W   = 16;
   localparam int unsigned SAMPLE_W = 8;
   localparam int unsigned DATA_MSB = 11;
   localparam int unsigned DATA_LSB = 4;

   localparam logic SRC_MAN  = 1'b0;
   localparam logic SRC_AUTO = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_CAPTURE
   } state_t;

   typedef struct packed {
      logic                src;
      logic [SAMPLE_W-1:0] value;
   } sample_t;

   // 12-bit converter result sits in the middle of the word; drop the 4 LSBs.
   function automatic logic [SAMPLE_W-1:0] extract_raw(input logic [WORD_W-1:0] word);
      return SAMPLE_W'(word >> DATA_LSB);
   endfunction

endpackage

// File: rtl/spi_acq_ctrl_if.sv
// Request / SPI handshake / display bundle around the acquisition controller.
interface spi_acq_ctrl_if;
   import spi_ctrl_pkg::*;

   logic                manReq;
   logic                autoEn;
   logic                spiStart;
   logic                spiDone;
   logic [WORD_W-1:0]   spiWord;
   logic [SAMPLE_W-1:0] sample;
   logic                sampleValid;
   logic                sampleSrc;
   logic                busy;
   logic                timeoutErr;

   modport master (
      input  manReq, autoEn, spiDone, spiWord,
      output spiStart, sample, sampleValid, sampleSrc, busy, timeoutErr
   );

   modport slave (
      output manReq, autoEn, spiDone, spiWord,
      input  spiStart, sample, sampleValid, sampleSrc, busy, timeoutErr
   );

endinterface

// File: rtl/spi_avg4.sv
// Running mean over a four-sample window: the incoming value plus the three
// stored before it. Only present when SPI_AVG_EN is defined.
`ifdef SPI_AVG_EN
module spi_avg4
   import spi_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [SAMPLE_W-1:0] raw,
   output logic [SAMPLE_W-1:0] avg_c
);

   localparam int unsigned DEPTH = 3;
   localparam int unsigned SUM_W = SAMPLE_W + 2;

   logic [SAMPLE_W-1:0] hist [DEPTH];
   logic                primed;
   logic [SUM_W-1:0]    sum_c;

   always_comb begin
      sum_c = SUM_W'(raw);
      for (int i = 0; i < int'(DEPTH); i++) begin
         sum_c = sum_c + SUM_W'(hist[i]);
      end
   end

   // Before the first capture the window is conceptually full of the new value.
   assign avg_c = primed ? sum_c[SUM_W-1:2] : raw;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         primed <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            hist[i] <= '0;
         end
      end else if (load) begin
         primed  <= 1'b1;
         hist[0] <= raw;
         hist[1] <= primed ? hist[0] : raw;
         hist[2] <= primed ? hist[1] : raw;
      end
   end

endmodule
`endif

// File: rtl/spi_acq_ctrl.sv
// Acquisition controller: arbitrates manual and periodic requests, drives the
// SPI master, supervises completion. SPI_AVG_EN enables four-sample averaging.
module spi_acq_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned PERIOD_CYC  = 10_000_000,
   parameter int unsigned TIMEOUT_CYC = 2048
) (
   input  logic           clk,
   input  logic           reset,
   spi_acq_ctrl_if.master bus
);

   localparam int unsigned PER_W = (PERIOD_CYC > 1)  ? $clog2(PERIOD_CYC)  : 1;
   localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

   state_t              state;
   state_t              state_nxt;
   logic                man_pend;
   logic                auto_pend;
   logic [PER_W-1:0]    per_cnt;
   logic                per_term_c;
   logic [TO_W-1:0]     to_cnt;
   logic                grant_man_c;
   logic                grant_auto_c;
   logic                capture_c;
   logic                abort_c;
   logic                src_grant;
   logic [SAMPLE_W-1:0] raw_c;
   logic [SAMPLE_W-1:0] value_c;
   sample_t             sample_q;
   logic                spi_start_q;
   logic                valid_q;
   logic                busy_q;
   logic                terr_q;

   // Free-running auto-sample period timer, held at zero while disabled.
   assign per_term_c = bus.autoEn && (per_cnt == PER_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         per_cnt <= '0;
      end else if (!bus.autoEn || per_term_c) begin
         per_cnt <= '0;
      end else begin
         per_cnt <= per_cnt + PER_W'(1);
      end
   end

   // One-deep request latches; a new request in the grant cycle is kept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         man_pend  <= 1'b0;
         auto_pend <= 1'b0;
      end else begin
         man_pend  <= bus.manReq | (man_pend & ~grant_man_c);
         auto_pend <= bus.autoEn & (per_term_c | (auto_pend & ~grant_auto_c));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      grant_man_c  = 1'b0;
      grant_auto_c = 1'b0;
      capture_c    = 1'b0;
      abort_c      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (man_pend) begin
               state_nxt   = ST_START;
               grant_man_c = 1'b1;
            end else if (auto_pend) begin
               state_nxt    = ST_START;
               grant_auto_c = 1'b1;
            end
         end
         ST_START: state_nxt = ST_WAIT;
         ST_WAIT: begin
            // Completion takes priority over a timeout landing in the same cycle.
            if (bus.spiDone) begin
               state_nxt = ST_CAPTURE;
               capture_c = 1'b1;
            end else if (to_cnt == TO_LAST) begin
               state_nxt = ST_IDLE;
               abort_c   = 1'b1;
            end
         end
         ST_CAPTURE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt <= '0;
      end else if (state == ST_START) begin
         to_cnt <= '0;
      end else if (state == ST_WAIT) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   assign raw_c = extract_raw(bus.spiWord);

`ifdef SPI_AVG_EN
   spi_avg4 u_avg (
      .clk   (clk),
      .reset (reset),
      .load  (capture_c),
      .raw   (raw_c),
      .avg_c (value_c)
   );
`else
   assign value_c = raw_c;
`endif

   // Outputs update on the edge leaving WAIT so sample lands one cycle after spiDone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         spi_start_q <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         terr_q      <= 1'b0;
         src_grant   <= SRC_MAN;
         sample_q    <= '0;
      end else begin
         spi_start_q <= (state_nxt == ST_START);
         busy_q      <= (state_nxt != ST_IDLE);
         valid_q     <= capture_c;
         if (grant_man_c) begin
            src_grant <= SRC_MAN;
         end else if (grant_auto_c) begin
            src_grant <= SRC_AUTO;
         end
         if (capture_c) begin
            sample_q.value <= value_c;
            sample_q.src   <= src_grant;
            terr_q         <= 1'b0;
         end else if (abort_c) begin
            terr_q <= 1'b1;
         end
      end
   end

   assign bus.spiStart    = spi_start_q;
   assign bus.sample      = sample_q.value;
   assign bus.sampleSrc   = sample_q.src;
   assign bus.sampleValid = valid_q;
   assign bus.busy        = busy_q;
   assign bus.timeoutErr  = terr_q;

endmodule

// File: tb/tb_spi_acq_ctrl.sv
// Self-checking bench for spi_acq_ctrl: directed scenarios plus randomized
// manual/auto traffic checked against a transaction-level reference model.
module tb_spi_acq_ctrl;
   import spi_ctrl_pkg::*;

   localparam int P = 100;
   localparam int T = 16;

   logic clk      = 1'b0;
   logic reset    = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   hist[$];
   logic exp_terr = 1'b0;

   spi_acq_ctrl_if bus ();

   spi_acq_ctrl #(.PERIOD_CYC(P), .TIMEOUT_CYC(T)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected display value for a completed transfer; updates the history.
   function automatic logic [7:0] model_sample(input logic [15:0] word);
      int raw;
      raw = (int'(word) >> 4) % 256;
`ifdef SPI_AVG_EN
      if (hist.size() == 0) repeat (3) hist.push_back(raw);
      hist.push_back(raw);
      while (hist.size() > 4) void'(hist.pop_front());
      return 8'((hist[0] + hist[1] + hist[2] + hist[3]) / 4);
`else
      return 8'(raw);
`endif
   endfunction

   task automatic test_reset();
      bus.manReq = 1'b0; bus.autoEn = 1'b0; bus.spiDone = 1'b0; bus.spiWord = '0;
      reset = 1'b0;
      hist.delete();
      exp_terr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.spiStart !== 1'b0) begin failures++; $display("FAIL reset_spiStart got=%b exp=0", bus.spiStart); end
      checks++; if (bus.sample !== 8'h00) begin failures++; $display("FAIL reset_sample got=%h exp=00", bus.sample); end
      checks++; if (bus.sampleValid !== 1'b0) begin failures++; $display("FAIL reset_sampleValid got=%b exp=0", bus.sampleValid); end
      checks++; if (bus.sampleSrc !== 1'b0) begin failures++; $display("FAIL reset_sampleSrc got=%b exp=0", bus.sampleSrc); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.timeoutErr !== 1'b0) begin failures++; $display("FAIL reset_timeoutErr got=%b exp=0", bus.timeoutErr); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_manual_basic();
      logic [7:0] exp;
      bus.manReq = 1'b1;
      tick();
      bus.manReq = 1'b0;
      checks++; if (bus.spiStart !== 1'b0) begin failures++; $display("FAIL basic_start_c1 got=%b exp=0", bus.spiStart); end
      tick();
      checks++; if (bus.spiStart !== 1'b1) begin failures++; $display("FAIL basic_start_c2 got=%b exp=1", bus.spiStart); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_c2 got=%b exp=1", bus.busy); end
      for (int c = 3; c <= 14; c++) begin
         tick();
         checks++; if (bus.sampleValid !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL basic_wait c=%0d valid=%b busy=%b exp valid=0 busy=1", c, bus.sampleValid, bus.busy); end
         if (c == 14) begin bus.spiDone = 1'b1; bus.spiWord = 16'h0AB0; end
      end
      exp = model_sample(16'h0AB0);
      tick();
      bus.spiDone = 1'b0;
      checks++; if (bus.sampleValid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.sampleValid); end
      checks++; if (bus.sample !== 8'hAB || exp !== 8'hAB) begin failures++; $display("FAIL basic_sample got=%h exp=ab", bus.sample); end
      checks++; if (bus.sampleSrc !== SRC_MAN) begin failures++; $display("FAIL basic_src got=%b exp=0", bus.sampleSrc); end
      tick();
      checks++; if (bus.sampleValid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", bus.sampleValid); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_drop got=%b exp=0", bus.busy); end
   endtask

   // d = cycles from start to spiDone (1..T), 0 = no answer (timeout).
   task automatic test_manual_random();
      for (int it = 0; it < 12; it++) begin
         int d;
         int last;
         logic [15:0] w;
         logic [7:0] exp;
         d = (it == 0) ? 0 : (it == 1) ? T : (it == 2) ? 1
             : (($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, T)));
         w = 16'($urandom);
         exp = 8'h00;
         if (d != 0) exp = model_sample(w);
         bus.spiDone = 1'b1;
         bus.spiWord = ~w;
         tick();
         bus.spiDone = 1'b0;
         checks++; if (bus.sampleValid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rnd_idle_done it=%0d valid=%b busy=%b exp 0 0", it, bus.sampleValid, bus.busy); end
         bus.manReq = 1'b1;
         tick();
         bus.manReq = 1'b0;
         checks++; if (bus.spiStart !== 1'b0) begin failures++; $display("FAIL rnd_start_early it=%0d got=%b exp=0", it, bus.spiStart); end
         tick();
         checks++; if (bus.spiStart !== 1'b1) begin failures++; $display("FAIL rnd_start it=%0d got=%b exp=1", it, bus.spiStart); end
         checks++; if (bus.timeoutErr !== exp_terr) begin failures++; $display("FAIL rnd_terr_sticky it=%0d got=%b exp=%b", it, bus.timeoutErr, exp_terr); end
         bus.spiDone = 1'b1;
         bus.spiWord = 16'hFFFF;
         last = (d == 0) ? T + 1 : d + 2;
         for (int i = 1; i <= last; i++) begin
            logic eb;
            logic ev;
            tick();
            eb = (d == 0) ? (i <= T) : (i <= d + 1);
            ev = (d != 0) && (i == d + 1);
            checks++; if (bus.busy !== eb) begin failures++; $display("FAIL rnd_busy it=%0d d=%0d i=%0d got=%b exp=%b", it, d, i, bus.busy, eb); end
            checks++; if (bus.sampleValid !== ev) begin failures++; $display("FAIL rnd_valid it=%0d d=%0d i=%0d got=%b exp=%b", it, d, i, bus.sampleValid, ev); end
            checks++; if (bus.spiStart !== 1'b0) begin failures++; $display("FAIL rnd_start_extra it=%0d i=%0d got=%b exp=0", it, i, bus.spiStart); end
            if (ev) begin
               checks++; if (bus.sample !== exp) begin failures++; $display("FAIL rnd_sample it=%0d got=%h exp=%h", it, bus.sample, exp); end
               checks++; if (bus.sampleSrc !== SRC_MAN) begin failures++; $display("FAIL rnd_src it=%0d got=%b exp=0", it, bus.sampleSrc); end
               checks++; if (bus.timeoutErr !== 1'b0) begin failures++; $display("FAIL rnd_terr_clear it=%0d got=%b exp=0", it, bus.timeoutErr); end
            end
            bus.spiDone = (i == d);
            bus.spiWord = w;
         end
         if (d == 0) begin
            checks++; if (bus.timeoutErr !== 1'b1) begin failures++; $display("FAIL rnd_terr_set it=%0d got=%b exp=1", it, bus.timeoutErr); end
            exp_terr = 1'b1;
         end else begin
            exp_terr = 1'b0;
         end
      end
   endtask

   task automatic test_auto();
      int done_at = -1;
      logic [15:0] w = '0;
      logic [7:0] exp = '0;
      bus.autoEn = 1'b1;
      for (int rel = 0; rel < 5 * P; rel++) begin
         logic es;
         logic ev;
         es = (rel >= P + 1) && ((rel - P - 1) % P == 0) && (rel < 3 * P + 20);
         ev = (done_at >= 0) && (rel == done_at + 1);
         checks++; if (bus.spiStart !== es) begin failures++; $display("FAIL auto_start rel=%0d got=%b exp=%b", rel, bus.spiStart, es); end
         checks++; if (bus.sampleValid !== ev) begin failures++; $display("FAIL auto_valid rel=%0d got=%b exp=%b", rel, bus.sampleValid, ev); end
         if (ev) begin
            checks++; if (bus.sample !== exp) begin failures++; $display("FAIL auto_sample rel=%0d got=%h exp=%h", rel, bus.sample, exp); end
            checks++; if (bus.sampleSrc !== SRC_AUTO) begin failures++; $display("FAIL auto_src rel=%0d got=%b exp=1", rel, bus.sampleSrc); end
         end
         if (bus.spiStart === 1'b1) begin
            done_at = rel + 10;
            w = 16'($urandom);
         end
         bus.spiDone = (rel == done_at);
         bus.spiWord = w;
         if (rel == done_at) exp = model_sample(w);
         if (rel == 3 * P + 20) bus.autoEn = 1'b0;
         tick();
      end
      bus.spiDone = 1'b0;
   endtask

   task automatic test_coincident();
      int done_at = -1;
      int starts = 0;
      logic [15:0] w = '0;
      logic [7:0] exp = '0;
      bus.autoEn = 1'b1;
      for (int rel = 0; rel < 3 * P; rel++) begin
         logic es;
         logic ev;
         es = (rel == P + 1) || (rel == P + 9);
         ev = (done_at >= 0) && (rel == done_at + 1);
         checks++; if (bus.spiStart !== es) begin failures++; $display("FAIL coin_start rel=%0d got=%b exp=%b", rel, bus.spiStart, es); end
         checks++; if (bus.sampleValid !== ev) begin failures++; $display("FAIL coin_valid rel=%0d got=%b exp=%b", rel, bus.sampleValid, ev); end
         if (ev) begin
            checks++; if (bus.sampleSrc !== ((starts == 1) ? SRC_MAN : SRC_AUTO)) begin failures++; $display("FAIL coin_src rel=%0d got=%b exp=%b", rel, bus.sampleSrc, (starts == 1) ? SRC_MAN : SRC_AUTO); end
            checks++; if (bus.sample !== exp) begin failures++; $display("FAIL coin_sample rel=%0d got=%h exp=%h", rel, bus.sample, exp); end
         end
         if (bus.spiStart === 1'b1) begin
            starts++;
            done_at = rel + 5;
            w = 16'($urandom);
         end
         bus.manReq  = (rel == P - 1);
         bus.spiDone = (rel == done_at);
         bus.spiWord = w;
         if (rel == done_at) exp = model_sample(w);
         if (rel == P + 30) bus.autoEn = 1'b0;
         tick();
      end
      bus.spiDone = 1'b0;
      bus.manReq = 1'b0;
      checks++; if (starts !== 2) begin failures++; $display("FAIL coin_count got=%0d exp=2", starts); end
   endtask

   task automatic test_reset_mid();
      bus.manReq = 1'b1;
      tick();
      bus.manReq = 1'b0;
      repeat (6) tick();
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_pre got=%b exp=1", bus.busy); end
      reset = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.sample !== 8'h00) begin failures++; $display("FAIL rmid_sample got=%h exp=00", bus.sample); end
      checks++; if (bus.sampleSrc !== 1'b0) begin failures++; $display("FAIL rmid_src got=%b exp=0", bus.sampleSrc); end
      checks++; if (bus.spiStart !== 1'b0 || bus.sampleValid !== 1'b0 || bus.timeoutErr !== 1'b0) begin failures++; $display("FAIL rmid_flags start=%b valid=%b terr=%b exp 0 0 0", bus.spiStart, bus.sampleValid, bus.timeoutErr); end
      hist.delete();
      exp_terr = 1'b0;
      tick();
      reset = 1'b1;
      repeat (2) tick();
      bus.spiDone = 1'b1;
      bus.spiWord = 16'h0FF0;
      tick();
      bus.spiDone = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.sampleValid !== 1'b0 || bus.busy !== 1'b0 || bus.sample !== 8'h00) begin failures++; $display("FAIL rmid_late_done i=%0d valid=%b busy=%b sample=%h exp 0 0 00", i, bus.sampleValid, bus.busy, bus.sample); end
         tick();
      end
   endtask

   task automatic test_sequence();
      logic [7:0] want [4];
`ifdef SPI_AVG_EN
      want = '{8'h10, 8'h14, 8'h1C, 8'h28};
`else
      want = '{8'h10, 8'h20, 8'h30, 8'h40};
`endif
      for (int k = 0; k < 4; k++) begin
         logic [15:0] w;
         logic [7:0] m;
         w = 16'((k + 1) * 256);
         m = model_sample(w);
         bus.manReq = 1'b1;
         tick();
         bus.manReq = 1'b0;
         tick();
         tick();
         bus.spiDone = 1'b1;
         bus.spiWord = w;
         tick();
         bus.spiDone = 1'b0;
         checks++; if (bus.sampleValid !== 1'b1) begin failures++; $display("FAIL seq_valid k=%0d got=%b exp=1", k, bus.sampleValid); end
         checks++; if (bus.sample !== want[k] || m !== want[k]) begin failures++; $display("FAIL seq_sample k=%0d got=%h exp=%h", k, bus.sample, want[k]); end
         tick();
         checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL seq_busy k=%0d got=%b exp=0", k, bus.busy); end
      end
   endtask

   initial begin
      test_reset();
      test_manual_basic();
      test_manual_random();
      test_auto();
      test_coincident();
      test_reset_mid();
      test_sequence();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t checks=%0d", $time, checks);
      $fatal(1, "bench time limit expired");
   end

endmodule
